// File: rtl/stream_mux_pkg.sv
// Shared types for the N-channel streaming multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  // Next channel index after idx, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // Scan channels in priority order ptr, ptr+1, ... and lock onto the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      logic [SEL_W-1:0] idx;
      idx = SEL_W'((32'(ptr) + 32'(k)) % 32'(N_CH));
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// channel choice and a single registered output stage.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  mode_t            mode_e;
  logic             can_load;
  logic             sel_ok;
  logic             xfer;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [N_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  assign mode_e   = mode_t'(mode);
  assign can_load = !out_valid || out_ready;
  assign sel_ok   = (int'(sel) < N_CH);

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Grant selection and ready generation; rst_n gating keeps ready low in reset
  // even though the empty output register would otherwise allow a load.
  always_comb begin
    in_ready  = '0;
    grant_idx = '0;
    case (mode_e)
      MODE_RR: begin
        if (arb_any) begin
          in_ready  = arb_gnt & {N_CH{can_load & rst_n}};
          grant_idx = arb_idx;
        end else begin
          in_ready  = '0;
        end
      end
      MODE_FIXED: begin
        if (sel_ok) begin
          in_ready[sel] = can_load & rst_n;
          grant_idx     = sel;
        end else begin
          in_ready = '0;
        end
      end
      default: begin
        in_ready  = '0;
        grant_idx = '0;
      end
    endcase
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and round-robin pointer; ptr only advances on RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*W +: W];
        out_ch    <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && (mode_e == MODE_RR)) begin
        ptr <= SEL_W'(wrap_inc(32'(grant_idx), 32'(N_CH)));
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed self-checking bench for stream_mux_n (4 channels, 8-bit data).
module tb_stream_mux_n;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic              clk;
  logic              rst_n;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  stream_mux_n #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_ch [5];
    exp_ch = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

    rst_n     = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;

    // Reset with every channel requesting
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);

    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_all_ch",   32'(out_ch),    32'(exp_ch[i]));
      chk("rr_all_data", 32'(out_data),  32'h11 * (32'(exp_ch[i]) + 32'd1));
      chk("rr_all_vld",  32'(out_valid), 32'd1);
    end

    // FIXED mode on channel 2; ptr is now 1
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid = 4'b0100;
    #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch",   32'(out_ch),   32'd2);
    in_valid = 4'b0000;
    #1;
    chk("fix_ready_novalid", 32'(in_ready), 32'b0100);
    tick();
    chk("fix_drain", 32'(out_valid), 32'd0);

    // Round-robin fairness between channels 1 and 3
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_fair", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_single", 32'(out_ch), 32'd3);
    end

    // Backpressure: ptr is 0, load 0x11 then stall
    in_valid = 4'b0001;
    tick();
    chk("bp_load", 32'(out_data), 32'h11);
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'b0000);
      tick();
      chk("bp_hold_data", 32'(out_data),  32'h11);
      chk("bp_hold_vld",  32'(out_valid), 32'd1);
      chk("bp_hold_ch",   32'(out_ch),    32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("bp_next_data", 32'(out_data),  32'h22);
    chk("bp_next_vld",  32'(out_valid), 32'd1);

    // Mode switch under stall; ptr is 2, so RR search 2,3,0 picks channel 0
    in_valid = 4'b0001;
    tick();
    chk("ms_load_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    tick();
    mode = 1'b0;
    sel  = 2'd3;
    tick();
    tick();
    chk("ms_hold_data", 32'(out_data), 32'h11);
    chk("ms_hold_ch",   32'(out_ch),   32'd0);
    out_ready = 1'b1;
    #1;
    chk("ms_fix_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("ms_next_ch",   32'(out_ch),   32'd3);
    chk("ms_next_data", 32'(out_data), 32'h44);
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("ms_ptr_kept", 32'(in_ready), 32'b0010);

    // Asynchronous reset between edges while holding a word
    tick();
    chk("ar_pre_vld", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld",   32'(out_valid), 32'd0);
    chk("ar_data",  32'(out_data),  32'h0);
    chk("ar_ready", 32'(in_ready),  32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_ptr_reset", 32'(in_ready), 32'b0001);
    tick();
    chk("ar_first_ch", 32'(out_ch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
